nrisc_ddata_mem: RTL and testbench



---
 rtl/nrisc_ddata_mem.sv | 116 +++++++++++
 tb/tb_nrisc_ddata_mem.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nrisc_ddata_mem.sv
// NRISC DDATA_CORE data-memory responder with sticky first-error capture.
// Define NRISC_DMEM_BYTE_EN to build byte-lane access modes.
module nrisc_ddata_mem #(
  parameter int TAM        = 16,
  parameter int N_DData    = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DData-1:0] DDATA_CORE_addr,
  input  logic [TAM-1:0]     DDATA_CORE_in,
  output logic [TAM-1:0]     DDATA_CORE_out,
  input  logic               DDATA_CORE_load,
  input  logic               DDATA_CORE_write,
  input  logic [2:0]         DDATA_CORE_ctrl,
  output logic [1:0]         dmem_err,
  output logic [N_DData-1:0] dmem_err_addr
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [TAM-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic [TAM-1:0]        rd_word;
  logic [TAM-1:0]        rd_data;
  logic                  rsv;
  logic                  we;
  logic                  re;
  logic [1:0]            code;

  assign idx     = DDATA_CORE_addr[DEPTH_LOG2-1:0];
  assign rd_word = mem[idx];

  generate
    if (DEPTH_LOG2 < N_DData) begin : g_rng
      assign in_range = ~|DDATA_CORE_addr[N_DData-1:DEPTH_LOG2];
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

`ifdef NRISC_DMEM_BYTE_EN
  logic       wr_lo;
  logic       wr_hi;
  logic [7:0] wd_hi;

  always_comb begin
    rsv     = 1'b0;
    wr_lo   = 1'b1;
    wr_hi   = 1'b1;
    wd_hi   = DDATA_CORE_in[15:8];
    rd_data = rd_word;
    case (DDATA_CORE_ctrl)
      3'b000: ;
      3'b001, 3'b101: begin
        wr_hi   = 1'b0;
        rd_data = {{8{DDATA_CORE_ctrl[2] & rd_word[7]}},
                   rd_word[7:0]};
      end
      3'b010, 3'b110: begin
        wr_lo   = 1'b0;
        wd_hi   = DDATA_CORE_in[7:0];
        rd_data = {{8{DDATA_CORE_ctrl[2] & rd_word[15]}},
                   rd_word[15:8]};
      end
      default: rsv = 1'b1;
    endcase
  end

  // Byte writes always take their data from the low input byte.
  always_ff @(posedge clk) begin
    if (we && wr_lo) mem[idx][7:0]  <= DDATA_CORE_in[7:0];
    if (we && wr_hi) mem[idx][15:8] <= wd_hi;
  end
`else
  logic unused_ctrl;

  assign unused_ctrl = ^DDATA_CORE_ctrl;
  assign rsv         = 1'b0;
  assign rd_data     = rd_word;

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= DDATA_CORE_in;
  end
`endif

  assign we = rst & DDATA_CORE_write & ~rsv & in_range;
  assign re = DDATA_CORE_load & ~DDATA_CORE_write & ~rsv;

  always_comb begin
    code = 2'b00;
    if (DDATA_CORE_load && DDATA_CORE_write)
      code = 2'b11;
    else if ((DDATA_CORE_load || DDATA_CORE_write) && rsv)
      code = 2'b10;
    else if ((DDATA_CORE_load || DDATA_CORE_write) && !in_range)
      code = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      DDATA_CORE_out <= '0;
      dmem_err       <= 2'b00;
      dmem_err_addr  <= '0;
    end else begin
      if (re)
        DDATA_CORE_out <= in_range ? rd_data : '0;
      if (dmem_err == 2'b00 && code != 2'b00) begin
        dmem_err      <= code;
        dmem_err_addr <= DDATA_CORE_addr;
      end
    end
  end

endmodule

// File: tb/tb_nrisc_ddata_mem.sv
// Scoreboard bench for nrisc_ddata_mem; adapts to NRISC_DMEM_BYTE_EN.
module tb_nrisc_ddata_mem;

`ifdef NRISC_DMEM_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        load;
  logic        write;
  logic [2:0]  ctrl;
  logic [1:0]  err;
  logic [15:0] err_addr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mdl [256];
  logic [15:0] exp_out   = '0;
  logic [1:0]  exp_err   = '0;
  logic [15:0] exp_eaddr = '0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  nrisc_ddata_mem dut (
    .clk              (clk),
    .rst              (rst),
    .DDATA_CORE_addr  (addr),
    .DDATA_CORE_in    (din),
    .DDATA_CORE_out   (dout),
    .DDATA_CORE_load  (load),
    .DDATA_CORE_write (write),
    .DDATA_CORE_ctrl  (ctrl),
    .dmem_err         (err),
    .dmem_err_addr    (err_addr)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_rsv(input logic [2:0] c);
    return BYTE_EN && (c == 3'b011 || c == 3'b100 || c == 3'b111);
  endfunction

  function automatic logic [15:0] fmt(input logic [15:0] w,
                                      input logic [2:0] c);
    if (!BYTE_EN) return w;
    case (c)
      3'b001:  return {8'h00, w[7:0]};
      3'b101:  return {{8{w[7]}}, w[7:0]};
      3'b010:  return {8'h00, w[15:8]};
      3'b110:  return {{8{w[15]}}, w[15:8]};
      default: return w;
    endcase
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [15:0] d,
                                        input logic [2:0] c);
    if (!BYTE_EN || c == 3'b000) return d;
    if (c[1:0] == 2'b01) return {old[15:8], d[7:0]};
    return {d[7:0], old[7:0]};
  endfunction

  task automatic access(input string tag, input logic r,
                        input logic ld, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [2:0] c);
    bit rs;
    bit inr;
    bit pushed;
    logic [1:0] code;
    rs     = is_rsv(c);
    inr    = (a < 16'd256);
    pushed = 1'b0;
    rst = r; load = ld; write = wr;
    addr = a; din = d; ctrl = c;
    if (!r) begin
      exp_out = '0; exp_err = '0; exp_eaddr = '0;
    end else begin
      if (ld && wr) code = 2'b11;
      else if ((ld || wr) && rs) code = 2'b10;
      else if ((ld || wr) && !inr) code = 2'b01;
      else code = 2'b00;
      if (ld && !wr && !rs) begin
        exp_out = inr ? fmt(mdl[a[7:0]], c) : 16'h0000;
        exp_q.push_back(exp_out);
        pushed = 1'b1;
      end
      if (wr && !rs && inr)
        mdl[a[7:0]] = merge(mdl[a[7:0]], d, c);
      if (exp_err == 2'b00 && code != 2'b00) begin
        exp_err = code; exp_eaddr = a;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1; load = 1'b0; write = 1'b0;
    if (pushed) check({tag, "/out"}, dout, exp_q.pop_front());
    else check({tag, "/hold"}, dout, exp_out);
    check({tag, "/err"}, {14'b0, err}, {14'b0, exp_err});
    check({tag, "/eaddr"}, err_addr, exp_eaddr);
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; write = 1'b0;
    addr = '0; din = '0; ctrl = '0;
    access("rst0", 0, 0, 0, 0, 0, 0);
    access("rst1", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++)
      access("pre", 1, 0, 1, 16'(i), 16'(i * 16'h0731 + 5), 0);

    access("w5", 1, 0, 1, 16'd5, 16'h1234, 0);
    access("l5", 1, 1, 0, 16'd5, 16'h0, 0);

    if (BYTE_EN) begin
      access("w7", 1, 0, 1, 16'd7, 16'hA5F0, 0);
      access("bw7", 1, 0, 1, 16'd7, 16'h003C, 3'b010);
      access("l7w", 1, 1, 0, 16'd7, 0, 3'b000);
      access("l7s", 1, 1, 0, 16'd7, 0, 3'b101);
      access("l7z", 1, 1, 0, 16'd7, 0, 3'b001);
      access("l7h", 1, 1, 0, 16'd7, 0, 3'b110);
      access("bw7l", 1, 0, 1, 16'd7, 16'h1180, 3'b101);
      access("l7hz", 1, 1, 0, 16'd7, 0, 3'b010);
      access("l7ls", 1, 1, 0, 16'd7, 0, 3'b101);
    end else begin
      access("c7l", 1, 1, 0, 16'd5, 0, 3'b111);
      access("c1w", 1, 0, 1, 16'd9, 16'hBEEF, 3'b001);
      access("c1l", 1, 1, 0, 16'd9, 0, 3'b110);
    end

    access("w1", 1, 0, 1, 16'd1, 16'h0011, 0);
    access("w2", 1, 0, 1, 16'd2, 16'h0022, 0);
    access("w3", 1, 0, 1, 16'd3, 16'h0033, 0);
    access("b1", 1, 1, 0, 16'd1, 0, 0);
    access("b2", 1, 1, 0, 16'd2, 0, 0);
    access("b3", 1, 1, 0, 16'd3, 0, 0);

    access("oor", 1, 1, 0, 16'h0100, 0, 0);
    access("rsv", 1, 1, 0, 16'd3, 0, 3'b111);
    access("oorw", 1, 0, 1, 16'h8000, 16'h5555, 0);

    access("rstl", 0, 1, 0, 16'd5, 0, 0);
    access("coll", 1, 1, 1, 16'd2, 16'h00AA, 0);
    access("l2", 1, 1, 0, 16'd2, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      logic [2:0]  c;
      bit ld, wr;
      a  = ($urandom_range(0, 9) == 0) ?
           16'(16'h0100 + $urandom_range(0, 255)) :
           16'($urandom_range(0, 15));
      c  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      ld = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 3) == 0);
      if (i == 30) access("rstr", 0, 0, 0, 0, 0, 0);
      access("rnd", 1, ld, wr, a, 16'($urandom), c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
